checking_serial_sink: RTL and testbench

CHECKING_SERIAL_SINK -- requirements
Module: checking_serial_sink

---
 rtl/checking_serial_sink.sv | 157 +++++++++++++++
 tb/tb_checking_serial_sink.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/checking_serial_sink.sv
// Serial flit receiver: start-bit framed, LSB-first deserialiser feeding a small FIFO,
// with slot reservation for backpressure and saturating rx/err/drop statistics.
module checking_serial_sink #(
    parameter int id     = 0,
    parameter int FLIT_W = 32,
    parameter int DEST_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data,
    output logic              busy,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [25:0]       rx_count,
    output logic [15:0]       err_count,
    output logic [7:0]        drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BIT_W = $clog2(FLIT_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [FLIT_W-1:0]   shift_q, shift_d;
    logic                frame_ok_q, frame_ok_d;
    logic                done_q, done_d;
    logic                done_ok_q, done_ok_d;
    logic                res_q, res_d;
    logic                busy_q, busy_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [FLIT_W-1:0]   flit_out_q, flit_out_d;
    logic [25:0]         rx_count_q, rx_count_d;
    logic [15:0]         err_count_q, err_count_d;
    logic [7:0]          drop_count_q, drop_count_d;
    logic [FLIT_W-1:0]   mem_q [DEPTH];
    logic                push, pop, drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        frame_ok_d = frame_ok_q;
        done_d     = 1'b0;
        done_ok_d  = done_ok_q;
        res_d      = res_q;

        // The completed frame sits in shift_q for one cycle, so it is pushed on the following edge.
        push = done_q && done_ok_q;
        drop = done_q && !done_ok_q;
        pop  = (count_q != '0) && flit_ready;

        if (push) res_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (data) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = '0;
                    frame_ok_d = !busy_q;
                    if (!busy_q) res_d = 1'b1;
                end
            end
            SHIFT: begin
                shift_d[bit_cnt_q] = data;
                if (bit_cnt_q == BIT_W'(FLIT_W - 1)) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    done_ok_d = frame_ok_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Head register tracks the next-state head so flit_out holds its value when empty.
        flit_out_d = flit_out_q;
        if (count_d != '0) begin
            if (count_q == '0 || (pop && count_q == CNT_W'(1)))
                flit_out_d = shift_q;
            else if (pop)
                flit_out_d = mem_q[rd_ptr_d];
        end

        busy_d = (int'(count_d) + int'(res_d)) >= DEPTH;

        rx_count_d   = (push && rx_count_q != '1) ? rx_count_q + 26'd1 : rx_count_q;
        err_count_d  = (push && shift_q[DEST_W-1:0] != DEST_W'(id) && err_count_q != '1)
                       ? err_count_q + 16'd1 : err_count_q;
        drop_count_d = (drop && drop_count_q != '1) ? drop_count_q + 8'd1 : drop_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            frame_ok_q   <= 1'b0;
            done_q       <= 1'b0;
            done_ok_q    <= 1'b0;
            res_q        <= 1'b0;
            busy_q       <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            flit_out_q   <= '0;
            rx_count_q   <= '0;
            err_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            frame_ok_q   <= frame_ok_d;
            done_q       <= done_d;
            done_ok_q    <= done_ok_d;
            res_q        <= res_d;
            busy_q       <= busy_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            flit_out_q   <= flit_out_d;
            rx_count_q   <= rx_count_d;
            err_count_q  <= err_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign busy       = busy_q;
    assign flit_out   = flit_out_q;
    assign flit_valid = (count_q != '0);
    assign rx_count   = rx_count_q;
    assign err_count  = err_count_q;
    assign drop_count = drop_count_q;
endmodule

// File: tb/tb_checking_serial_sink.sv
// Scenario bench for checking_serial_sink (id=3, 32-bit flits, depth 2) with a pop-side scoreboard.
module tb_checking_serial_sink;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data = 1'b0;
    logic        busy;
    logic [31:0] flit_out;
    logic        flit_valid;
    logic        flit_ready = 1'b0;
    logic [25:0] rx_count;
    logic [15:0] err_count;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    checking_serial_sink #(.id(3), .FLIT_W(32), .DEST_W(4), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .data(data), .busy(busy),
        .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
        .rx_count(rx_count), .err_count(err_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Every pop is compared against the oldest expected flit.
    always @(negedge clk) begin
        if (flit_valid && flit_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h, expected no flit", flit_out);
            end else begin
                logic [31:0] exp_f;
                exp_f = sb.pop_front();
                if (flit_out !== exp_f) begin
                    errors++;
                    $display("FAIL pop_order: got %h, expected %h", flit_out, exp_f);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] f);
        data = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            data = f[i];
            tick();
        end
        data = 1'b0;
    endtask

    task automatic apply_reset();
        data = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n;
        flit_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || flit_valid) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0 || flit_valid) begin
            errors++;
            $display("FAIL drain_timeout: %0d flits left, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        data = 1'b1;
        tick();
        tick();
        checks += 6;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b, expected 1", busy); end
        if (flit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", flit_valid); end
        if (flit_out !== 32'h0) begin errors++; $display("FAIL reset_flit_out: got %h, expected 0", flit_out); end
        if (rx_count !== 26'h0) begin errors++; $display("FAIL reset_rx: got %h, expected 0", rx_count); end
        if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err: got %h, expected 0", err_count); end
        if (drop_count !== 8'h0) begin errors++; $display("FAIL reset_drop: got %h, expected 0", drop_count); end
        data = 1'b0;
        reset = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_reset: got %b, expected 1", busy); end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_release: got %b, expected 0", busy); end
    endtask

    task automatic test_basic();
        apply_reset();
        flit_ready = 1'b1;
        sb.push_back(32'h0000_A5A3);
        send_frame(32'h0000_A5A3);
        checks++;
        if (flit_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b, expected 0", flit_valid); end
        tick();
        checks += 4;
        if (flit_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b, expected 1", flit_valid); end
        if (flit_out !== 32'h0000_A5A3) begin errors++; $display("FAIL basic_flit: got %h, expected 0000a5a3", flit_out); end
        if (rx_count !== 26'd1) begin errors++; $display("FAIL basic_rx: got %0d, expected 1", rx_count); end
        if (err_count !== 16'd0) begin errors++; $display("FAIL basic_err: got %0d, expected 0", err_count); end
        tick();
        checks += 2;
        if (flit_valid !== 1'b0) begin errors++; $display("FAIL basic_single_cycle: got %b, expected 0", flit_valid); end
        if (flit_out !== 32'h0000_A5A3) begin errors++; $display("FAIL basic_hold: got %h, expected 0000a5a3", flit_out); end
    endtask

    task automatic test_dest_err();
        apply_reset();
        flit_ready = 1'b1;
        sb.push_back(32'h1234_5675);
        send_frame(32'h1234_5675);
        tick();
        checks += 2;
        if (rx_count !== 26'd1) begin errors++; $display("FAIL dest_rx: got %0d, expected 1", rx_count); end
        if (err_count !== 16'd1) begin errors++; $display("FAIL dest_err: got %0d, expected 1", err_count); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] b;
        int n;
        apply_reset();
        flit_ready = 1'b0;
        b = 32'h2222_0013;
        sb.push_back(32'h1111_0003);
        sb.push_back(b);
        sb.push_back(32'h3333_0023);
        send_frame(32'h1111_0003);
        data = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_rise: got %b, expected 1", busy); end
        for (int i = 0; i < 32; i++) begin
            data = b[i];
            tick();
        end
        data = 1'b0;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_hold: got %b, expected 1", busy); end
        flit_ready = 1'b1;
        tick();
        flit_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_fall: got %b, expected 0", busy); end
        n = 0;
        while (busy && n < 50) begin tick(); n++; end
        send_frame(32'h3333_0023);
        drain();
        checks += 2;
        if (rx_count !== 26'd3) begin errors++; $display("FAIL bp_rx: got %0d, expected 3", rx_count); end
        if (drop_count !== 8'd0) begin errors++; $display("FAIL bp_drop: got %0d, expected 0", drop_count); end
    endtask

    task automatic test_overflow();
        apply_reset();
        flit_ready = 1'b0;
        sb.push_back(32'hAAAA_5553);
        sb.push_back(32'hBBBB_6663);
        send_frame(32'hAAAA_5553);
        send_frame(32'hBBBB_6663);
        send_frame(32'hCCCC_7773);
        tick();
        checks += 2;
        if (rx_count !== 26'd2) begin errors++; $display("FAIL ovf_rx: got %0d, expected 2", rx_count); end
        if (drop_count !== 8'd1) begin errors++; $display("FAIL ovf_drop: got %0d, expected 1", drop_count); end
        drain();
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        flit_ready = 1'b1;
        data = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            data = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        tick();
        data = 1'b0;
        reset = 1'b0;
        tick();
        sb.push_back(32'h0000_0001);
        send_frame(32'h0000_0001);
        tick();
        checks += 2;
        if (flit_out !== 32'h1) begin errors++; $display("FAIL mid_flit: got %h, expected 00000001", flit_out); end
        if (rx_count !== 26'd1) begin errors++; $display("FAIL mid_rx: got %0d, expected 1", rx_count); end
        drain();
        checks += 2;
        if (drop_count !== 8'd0) begin errors++; $display("FAIL mid_drop: got %0d, expected 0", drop_count); end
        if (err_count !== 16'd1) begin errors++; $display("FAIL mid_err: got %0d, expected 1", err_count); end
    endtask

    task automatic test_saturation();
        apply_reset();
        flit_ready = 1'b1;
        force dut.rx_count_q = 26'h3FF_FFFE;
        tick();
        release dut.rx_count_q;
        tick();
        checks++;
        if (rx_count !== 26'h3FF_FFFE) begin errors++; $display("FAIL sat_preload: got %h, expected 3fffffe", rx_count); end
        for (int k = 0; k < 3; k++) begin
            logic [31:0] f;
            f = 32'h0000_0103 + 32'(k << 8);
            sb.push_back(f);
            send_frame(f);
            tick();
            checks++;
            if (rx_count !== 26'h3FF_FFFF) begin
                errors++;
                $display("FAIL sat_rx_%0d: got %h, expected 3ffffff", k, rx_count);
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dest_err();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
